// File: rtl/at24c02_pkg.sv
// Shared types and defaults for the AT24C02 transfer sequencer.
package at24c02_pkg;

  localparam int unsigned CtlAddrW       = 11;
  localparam int unsigned DefPageSize    = 8;
  localparam int unsigned DefWrCycleClks = 250000;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StStart,
    StData,
    StWaitLow,
    StWaitIdle,
    StWrDelay,
    StFinish
  } xfer_state_t;

endpackage

// File: rtl/at24c02_xfer_seq_if.sv
// User-side command, write-data and read-data streams of the transfer sequencer.
interface at24c02_xfer_seq_if #(
  parameter int unsigned ADDR_W = 11
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0]        cmd_len;
  logic              cmd_wr;
  logic [7:0]        wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_wr, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_wr, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last
  );

endinterface

// File: rtl/wr_cycle_timer.sv
// Counts out the EEPROM internal write-cycle time; done_o marks the last waiting cycle.
module wr_cycle_timer #(
  parameter int unsigned CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CntW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/at24c02_xfer_seq.sv
// Splits block transfers into page-aligned write bursts / single read sequences and
// drives the AT24C02 controller's request/beat/last handshake.
module at24c02_xfer_seq
  import at24c02_pkg::*;
#(
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned PAGE_SIZE     = DefPageSize,
  parameter int unsigned WR_CYCLE_CLKS = DefWrCycleClks
) (
  input  logic                clk_i,
  input  logic                rst_i,
  at24c02_xfer_seq_if.slave   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [CtlAddrW-1:0] ctl_address_o,
  output logic                ctl_wr_en_o,
  output logic [7:0]          ctl_din_o,
  input  logic [7:0]          ctl_dout_i,
  input  logic                ctl_ready_i,
  output logic                ctl_parent_ready_o,
  output logic                ctl_last_o
);

  localparam int unsigned PgW = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;

  xfer_state_t       state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [8:0]        total_rem_q;
  logic [8:0]        chunk_rem_q;
  logic              is_wr_q;
  logic              busy_q;
  logic              last_seen_q;

  logic [8:0] page_room;
  logic [8:0] burst_len;
  logic       final_byte;
  logic       rd_gate;
  logic       beat;
  logic       tmr_start;
  logic       tmr_done;

  always_comb begin
    page_room = 9'(PAGE_SIZE) - 9'(cur_addr_q[PgW-1:0]);
    if (!is_wr_q || (total_rem_q < page_room)) begin
      burst_len = total_rem_q;
    end else begin
      burst_len = page_room;
    end
  end

  // The controller registers last one cycle late, so the final read byte is
  // withheld on the first cycle it is offered.
  always_comb begin
    final_byte         = (chunk_rem_q == 9'd1);
    rd_gate            = !final_byte || last_seen_q;
    bus.cmd_ready      = (state_q == StIdle);
    bus.wr_ready       = 1'b0;
    bus.rd_valid       = 1'b0;
    bus.rd_last        = 1'b0;
    bus.rd_data        = '0;
    ctl_address_o      = '0;
    ctl_wr_en_o        = 1'b0;
    ctl_din_o          = '0;
    ctl_parent_ready_o = 1'b0;
    ctl_last_o         = 1'b0;
    beat               = 1'b0;
    tmr_start          = (state_q == StWaitIdle) && ctl_ready_i && is_wr_q;
    unique case (state_q)
      StStart: begin
        ctl_parent_ready_o = 1'b1;
        ctl_address_o      = CtlAddrW'(cur_addr_q);
        ctl_wr_en_o        = is_wr_q;
      end
      StData: begin
        ctl_address_o = CtlAddrW'(cur_addr_q);
        ctl_wr_en_o   = is_wr_q;
        ctl_last_o    = final_byte;
        if (is_wr_q) begin
          ctl_din_o          = bus.wr_data;
          ctl_parent_ready_o = bus.wr_valid;
          bus.wr_ready       = ctl_ready_i;
          beat               = bus.wr_valid && ctl_ready_i;
        end else begin
          bus.rd_data        = ctl_dout_i;
          bus.rd_last        = final_byte;
          bus.rd_valid       = ctl_ready_i && rd_gate;
          ctl_parent_ready_o = bus.rd_ready && rd_gate;
          beat               = bus.rd_ready && ctl_ready_i && rd_gate;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      total_rem_q <= '0;
      chunk_rem_q <= '0;
      is_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            cur_addr_q  <= bus.cmd_addr;
            total_rem_q <= bus.cmd_len + 9'd1;
            is_wr_q     <= bus.cmd_wr;
            busy_q      <= 1'b1;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          chunk_rem_q <= burst_len;
          state_q     <= StStart;
        end
        StStart: begin
          last_seen_q <= 1'b0;
          if (ctl_ready_i) state_q <= StData;
        end
        StData: begin
          if (!is_wr_q && final_byte && ctl_ready_i) last_seen_q <= 1'b1;
          if (beat) begin
            chunk_rem_q <= chunk_rem_q - 9'd1;
            total_rem_q <= total_rem_q - 9'd1;
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            if (final_byte) state_q <= StWaitLow;
          end
        end
        StWaitLow: begin
          if (!ctl_ready_i) state_q <= StWaitIdle;
        end
        StWaitIdle: begin
          if (ctl_ready_i) state_q <= is_wr_q ? StWrDelay : StFinish;
        end
        StWrDelay: begin
          if (tmr_done) state_q <= (total_rem_q != '0) ? StCalc : StFinish;
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == StFinish);

  wr_cycle_timer #(
    .CYCLES (WR_CYCLE_CLKS)
  ) u_wr_cycle_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (tmr_start),
    .done_o  (tmr_done)
  );

endmodule

// File: tb/tb_at24c02_xfer_seq.sv
// Randomized bench: behavioural AT24C02 controller + EEPROM model and a transfer-level
// reference for burst splitting, data and timing.
module tb_at24c02_xfer_seq;

  localparam int unsigned AW      = 11;
  localparam int unsigned PG      = 8;
  localparam int unsigned WR_CLKS = 20;
  localparam int          MEM_SZ  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, done;
  logic [10:0] ctl_address;
  logic        ctl_wr_en, ctl_ready, ctl_parent_ready, ctl_last;
  logic [7:0]  ctl_din, ctl_dout;

  always #5 clk = ~clk;

  at24c02_xfer_seq_if #(.ADDR_W(AW)) bus ();

  at24c02_xfer_seq #(
    .ADDR_W        (AW),
    .PAGE_SIZE     (PG),
    .WR_CYCLE_CLKS (WR_CLKS)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .bus                (bus),
    .busy_o             (busy),
    .done_o             (done),
    .ctl_address_o      (ctl_address),
    .ctl_wr_en_o        (ctl_wr_en),
    .ctl_din_o          (ctl_din),
    .ctl_dout_i         (ctl_dout),
    .ctl_ready_i        (ctl_ready),
    .ctl_parent_ready_o (ctl_parent_ready),
    .ctl_last_o         (ctl_last)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device model state and transfer observations.
  logic [7:0] eeprom  [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];
  int   cst = 0, ccnt = 0, caddr = 0;
  bit   cwr = 0, clast_q = 0, cfirst = 0, fin;
  int   seq_addr[$], seq_len[$], last_idx[$];
  bit   seq_wr[$];
  int   cur_len = 0, wbyte = 0, viol = 0, cyc = 0, done_cnt = 0;
  int   wend = 0, rend = 0;
  bit   wpend = 0, last_wr = 0, cmd_acc = 0;
  logic [7:0] wr_q[$];
  logic [8:0] rd_got[$];
  int   wduty = 100, rduty = 100;

  initial begin
    forever begin
      @(negedge clk);
      ctl_ready    = (cst == 0) || (cst == 2);
      ctl_dout     = eeprom[caddr];
      bus.wr_valid = (wr_q.size() > 0) && (int'($urandom_range(99)) < wduty);
      bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
      bus.rd_ready = int'($urandom_range(99)) < rduty;
      #1;
      cyc++;
      if (rst) begin
        cst = 0; clast_q = 0; cfirst = 0; wpend = 0;
      end else begin
        if (bus.cmd_valid && bus.cmd_ready) cmd_acc = 1;
        if (done) begin
          done_cnt++;
          if (last_wr) check_eq("twr_before_done", 32'((cyc - wend) > int'(WR_CLKS)), 1);
          else check_eq("no_twr_after_read", 32'((cyc - rend) < int'(WR_CLKS)), 1);
          wpend = 0;
        end
        if (bus.wr_valid && bus.wr_ready) void'(wr_q.pop_front());
        if (bus.rd_valid && bus.rd_ready) rd_got.push_back({bus.rd_last, bus.rd_data});
        if (!cwr && cst == 2 && cfirst && ctl_last && bus.rd_valid) viol++;
        case (cst)
          0: if (ctl_parent_ready) begin
            if (wpend) check_eq("twr_between", 32'((cyc - wend) > int'(WR_CLKS)), 1);
            wpend = 0;
            seq_addr.push_back(int'(ctl_address));
            seq_wr.push_back(ctl_wr_en);
            cur_len = 0;
            caddr   = int'(ctl_address);
            cwr     = ctl_wr_en;
            cst     = 1;
            ccnt    = int'($urandom_range(1, 4));
          end
          1, 3: begin
            ccnt--;
            if (ccnt == 0) begin cst = 2; cfirst = 1; end
          end
          2: if (ctl_parent_ready) begin
            cur_len++;
            if (cwr) begin
              eeprom[caddr] = ctl_din;
              wbyte++;
              if (ctl_last) last_idx.push_back(wbyte);
              fin = ctl_last;
            end else begin
              if (cfirst && ctl_last) viol++;
              fin = clast_q;
            end
            if (fin) begin
              seq_len.push_back(cur_len);
              cst = 4; ccnt = int'($urandom_range(2, 5));
              last_wr = cwr;
              if (cwr) begin wend = cyc; wpend = 1; end else rend = cyc;
            end else begin
              // Real device rolls over inside the page on writes.
              caddr = cwr ? ((caddr & ~(PG - 1)) | ((caddr + 1) & (PG - 1)))
                          : ((caddr + 1) % MEM_SZ);
              cst = 3; ccnt = int'($urandom_range(1, 3));
            end
          end else cfirst = 0;
          4: begin
            ccnt--;
            if (ccnt == 0) cst = 0;
          end
          default: cst = 0;
        endcase
        clast_q = ctl_last;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".cmd_ready"}, bus.cmd_ready, 1);
    check_eq({tag, ".wr_ready"}, bus.wr_ready, 0);
    check_eq({tag, ".rd_valid"}, bus.rd_valid, 0);
    check_eq({tag, ".rd_last"}, bus.rd_last, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".parent_ready"}, ctl_parent_ready, 0);
    check_eq({tag, ".ctl_last"}, ctl_last, 0);
    check_eq({tag, ".ctl_address"}, ctl_address, 0);
    check_eq({tag, ".ctl_wr_en"}, ctl_wr_en, 0);
  endtask

  task automatic issue_cmd(input int addr, input int n, input bit wr);
    bit acc = 0;
    seq_addr.delete(); seq_wr.delete(); seq_len.delete(); last_idx.delete();
    rd_got.delete(); wbyte = 0; done_cnt = 0; viol = 0;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        wr_q.push_back(b);
        ref_mem[(addr + i) % MEM_SZ] = b;
      end
    end
    @(negedge clk);
    cmd_acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = 9'(n - 1);
    bus.cmd_wr    = wr;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_acc;
    end
    bus.cmd_valid = 1'b0;
    check_eq("cmd_accept", acc, 1);
    check_eq("busy_on", busy, 1);
  endtask

  task automatic run_cmd(input int addr, input int n, input bit wr);
    bit got = 0;
    int a, rem, k, cum, c;
    issue_cmd(addr, n, wr);
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      got = (done_cnt > 0);
    end
    check_eq("done_seen", got, 1);
    repeat (5) @(negedge clk);
    check_eq("done_once", done_cnt, 1);
    check_eq("busy_off", busy, 0);
    check_eq("viol", viol, 0);
    a = addr; rem = n; k = 0; cum = 0;
    while (rem > 0) begin
      c = rem;
      if (wr && (PG - (a % PG)) < rem) c = PG - (a % PG);
      if (k < seq_addr.size()) begin
        check_eq("seq_addr", seq_addr[k], a);
        check_eq("seq_wr", seq_wr[k], wr);
      end
      if (k < seq_len.size()) check_eq("seq_len", seq_len[k], c);
      cum += c;
      if (wr && k < last_idx.size()) check_eq("last_pos", last_idx[k], cum);
      a = (a + c) % MEM_SZ; rem -= c; k++;
    end
    check_eq("seq_count", seq_addr.size(), k);
    if (wr) begin
      check_eq("last_count", last_idx.size(), k);
      check_eq("wr_left", wr_q.size(), 0);
      for (int i = 0; i < n; i++)
        check_eq("mem", eeprom[(addr + i) % MEM_SZ], ref_mem[(addr + i) % MEM_SZ]);
    end else begin
      check_eq("rd_count", rd_got.size(), n);
      for (int i = 0; i < n && i < rd_got.size(); i++) begin
        check_eq("rd_data", rd_got[i][7:0], ref_mem[(addr + i) % MEM_SZ]);
        check_eq("rd_last", rd_got[i][8], 32'(i == n - 1));
      end
    end
  endtask

  initial begin
    bit hit = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_wr = 1'b0;
    for (int i = 0; i < MEM_SZ; i++) begin
      eeprom[i]  = 8'($urandom);
      ref_mem[i] = eeprom[i];
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    wduty = 100; rduty = 100;
    run_cmd('h005, 20, 1);
    run_cmd('h7FE, 4, 1);
    run_cmd('h0FE, 4, 0);
    run_cmd('h010, 1, 0);

    wduty = 30; rduty = 30;
    run_cmd('h123, 12, 1);
    run_cmd('h123, 12, 0);

    for (int t = 0; t < 8; t++) begin
      wduty = int'($urandom_range(30, 100));
      rduty = int'($urandom_range(30, 100));
      run_cmd(int'($urandom_range(MEM_SZ - 1)), int'($urandom_range(1, 24)),
              1'($urandom_range(1)));
    end

    // Abort in the middle of the second write burst.
    wduty = 100; rduty = 100;
    issue_cmd('h005, 20, 1);
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = (seq_addr.size() == 2) && (cst == 2);
    end
    check_eq("abort_reached", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    wr_q.delete();
    repeat (WR_CLKS * 3) @(negedge clk);
    check_eq("abort_no_done", done_cnt, 0);
    run_cmd('h100, 2, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/at24c02_xfer_seq.md
Name: at24c02_xfer_seq

Overview:
Sits directly upstream of the AT24C02 EEPROM controller. Accepts block transfer commands (start address, length, direction) plus write-data and read-data byte streams. Splits writes into page-aligned bursts and enforces the EEPROM internal write-cycle time between bursts. Issues each read as one sequential-read sequence, and drives the controller's control interface with correct start, beat and last timing.

Parameters:
ADDR_W, 11, width of EEPROM byte address; address arithmetic wraps modulo 2^ADDR_W
PAGE_SIZE, 8, EEPROM page size in bytes; power of two, 2..256
WR_CYCLE_CLKS, 250000, clocks to wait after each write burst (tWR = 5 ms at 50 MHz); must be ≥1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; controller shares it
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  ADDR_W  first byte address
cmd_len  in  9  byte count minus 1 (0..255 → 1..256 bytes)
cmd_wr  in  1  1 = write, 0 = read
wr_data  in  8  write byte stream
wr_valid  in  1  wr_data valid
wr_ready  out  1  byte consumed when wr_valid && wr_ready
rd_data  out  8  read byte stream
rd_valid  out  1  rd_data valid
rd_ready  in  1  downstream accepts rd_data
rd_last  out  1  marks final read byte of a command
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
ctl_address  out  11  to controller address (zero-extended/truncated from ADDR_W)
ctl_wr_en  out  1  to controller wr_en
ctl_din  out  8  to controller din
ctl_dout  in  8  from controller dout
ctl_ready  in  1  from controller ready
ctl_parent_ready  out  1  to controller parent_ready
ctl_last  out  1  to controller last

Behaviour:
- Reset: state IDLE. cmd_ready=1; wr_ready, rd_valid, rd_last, busy, done, ctl_parent_ready, ctl_last = 0; ctl_address = 0; ctl_wr_en = 0.
- Reset mid-operation returns to IDLE immediately. Partially consumed streams are abandoned, and no done pulse is issued.
- Registers: cur_addr, total_rem (bytes left in command), chunk_rem (bytes left in current burst), is_wr.
- States:
  - IDLE: cmd_ready=1. On accept, latch cur_addr=cmd_addr, total_rem=cmd_len+1, is_wr=cmd_wr, busy←1. Go to CALC.
  - CALC (1 cycle): for a write, chunk_rem = min(total_rem, PAGE_SIZE − (cur_addr mod PAGE_SIZE)); for a read, chunk_rem = total_rem. Go to START.
  - START: ctl_parent_ready=1, ctl_address=cur_addr, ctl_wr_en=is_wr. When ctl_ready=1, the controller latches the request; go to DATA.
  - DATA, write: ctl_din=wr_data; ctl_parent_ready=wr_valid; wr_ready=ctl_ready; ctl_last=(chunk_rem==1). Beat = wr_valid && ctl_ready; each beat decrements chunk_rem and total_rem and increments cur_addr (mod 2^ADDR_W). The final beat goes to WAIT_LOW.
  - DATA, read: rd_data=ctl_dout; ctl_last=(chunk_rem==1); rd_last=(chunk_rem==1). For non-final bytes: rd_valid=ctl_ready and ctl_parent_ready=rd_ready.
  - DATA, read, final byte: the controller registers last one cycle late. Both rd_valid and ctl_parent_ready are held low on the first cycle ctl_ready is seen high for that byte, then pass through as above. Length-1 reads follow the same rule.
  - DATA, read, beats: beat = rd_ready && rd_valid; each beat decrements counters. The final beat goes to WAIT_LOW.
  - WAIT_LOW: wait for ctl_ready=0 (controller leaves data phase). Then go to WAIT_IDLE.
  - WAIT_IDLE: wait for ctl_ready=1 (controller back in its idle). Then go to WR_DELAY if is_wr, else FINISH.
  - WR_DELAY: count WR_CYCLE_CLKS cycles with ctl_parent_ready=0. Then go to CALC if total_rem≠0, else FINISH.
  - FINISH: done=1 for one cycle, busy←0, go to IDLE.
- Write data beyond a burst is not consumed until the next burst's DATA. There is no internal data buffering; wr_ready is never high outside DATA.
- A new command is accepted only in IDLE. Accepting a command in the FINISH→IDLE cycle is not allowed; the earliest accept is the following cycle.

Decomposition:
- Package at24c02_pkg holds:
  - the state enum xfer_state_t (IDLE, CALC, START, DATA, WAIT_LOW, WAIT_IDLE, WR_DELAY, FINISH);
  - localparams for the default page size and tWR clock count;
  - the 11-bit controller address width.
- One sub-module, wr_cycle_timer: load/start input, done pulse, counter width $clog2(WR_CYCLE_CLKS+1).

Test Plan:
- Write 20 bytes at 0x005 (PAGE_SIZE 8) → four controller sequences with bursts 3@0x005, 8@0x008, 8@0x010, 1@0x018. ctl_last is on the 3rd/11th/19th/20th bytes, ≥WR_CYCLE_CLKS idle cycles follow each burst, and one done pulse follows the last delay.
- Write 4 bytes at 0x7FE → bursts 2@0x7FE then 2@0x000 (address wrap); data matches in the EEPROM model.
- Read 4 bytes at 0x0FE → one sequence, ctl_wr_en=0; rd_data equals model bytes 0x0FE..0x101; rd_last only on the 4th byte; no write-cycle delay; done pulses.
- Read 1 byte at 0x010 → rd_valid is withheld on the first ctl_ready cycle; exactly one byte is returned with rd_last=1, and the controller issues a stop.
- Backpressure: toggle wr_valid/rd_ready at random with 30% duty on a 12-byte write then a 12-byte read → data is intact and counts are exact, with no extra or missing beats.
- Assert rst during the second write burst → all outputs are at reset values the next cycle, cmd_ready=1, and a subsequent 2-byte read completes normally.
